// File: rtl/cic_decimator.sv
// Decimator behind the CIC moving-sum: keeps one sample in R, removes the CIC gain with a
// rounded arithmetic shift, saturates, and queues results in a 2-entry output buffer.
module cic_decimator #(
    parameter int width_H = 5,
    parameter int width_W = 20,
    parameter int R       = 32,
    parameter int PHASE   = 0,
    parameter int SHIFT   = 5,
    parameter int OUT_W   = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              data_i_en,
    input  logic signed [width_H+width_W-1:0] data_i,
    input  logic                              sync_i,
    input  logic                              overflow_clr,
    output logic                              data_o_valid,
    input  logic                              data_o_ready,
    output logic signed [OUT_W-1:0]           data_o,
    output logic                              sat_o,
    output logic                              overflow
);

    localparam int IW    = width_H + width_W;
    localparam int IW1   = IW + 1;
    localparam int CNT_W = (R > 1) ? $clog2(R) : 1;

    localparam logic [CNT_W-1:0]  PHASE_C = CNT_W'(PHASE);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(R - 1);
    // Half an LSB of the shifted result; zero when SHIFT is 0, which makes the stage a pass-through.
    localparam logic signed [IW:0] ROUND_C = IW1'((2 ** SHIFT) / 2);
    localparam logic signed [IW:0] MAX_C   = IW1'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IW:0] MIN_C   = ~MAX_C;

    function automatic logic signed [IW:0] round_shift(input logic signed [IW-1:0] x);
        logic signed [IW:0] sum;
        sum = {x[IW-1], x} + ROUND_C;
        return sum >>> SHIFT;
    endfunction

    // Returns {sat, clamped value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [IW:0] v);
        if (v > MAX_C) begin
            return {1'b1, MAX_C[OUT_W-1:0]};
        end else if (v < MIN_C) begin
            return {1'b1, MIN_C[OUT_W-1:0]};
        end
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_next;
    logic             keep;

    // A sync strobe realigns the counter so the coincident sample already counts as phase 0.
    always_comb begin
        cnt_eff  = sync_i ? '0 : cnt;
        keep     = data_i_en && (cnt_eff == PHASE_C);
        cnt_next = cnt;
        if (data_i_en) begin
            cnt_next = (cnt_eff == LAST_C) ? '0 : cnt_eff + 1'b1;
        end else if (sync_i) begin
            cnt_next = '0;
        end
    end

    logic                    vld_p0, vld_p1, vld_p2;
    logic signed [IW-1:0]    data_p0;
    logic signed [IW:0]      data_p1;
    logic signed [OUT_W-1:0] data_p2;
    logic                    sat_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            vld_p0 <= keep;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        // p0: captured sample
        data_p0 <= data_i;
        // p1: gain removed with round-half-up
        data_p1 <= round_shift(data_p0);
        // p2: clamped to output range
        {sat_p2, data_p2} <= saturate(data_p1);
    end

    logic [1:0]              count;
    logic [1:0]              count_next;
    logic signed [OUT_W-1:0] head_data, tail_data;
    logic                    head_sat, tail_sat;
    logic                    pop, push, drop;
    logic                    head_from_new, head_from_tail, tail_load;

    // A pop in the same cycle frees a slot, so a full buffer only drops when nothing leaves.
    always_comb begin
        pop            = (count != 2'd0) && data_o_ready;
        push           = vld_p2 && ((count != 2'd2) || pop);
        drop           = vld_p2 && (count == 2'd2) && !pop;
        head_from_new  = push && ((count == 2'd0) || ((count == 2'd1) && pop));
        head_from_tail = pop && (count == 2'd2);
        tail_load      = push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop));
        count_next     = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= 2'd0;
            overflow  <= 1'b0;
            head_data <= '0;
            head_sat  <= 1'b0;
        end else begin
            count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (head_from_new) begin
                head_data <= data_p2;
                head_sat  <= sat_p2;
            end else if (head_from_tail) begin
                head_data <= tail_data;
                head_sat  <= tail_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tail_load) begin
            tail_data <= data_p2;
            tail_sat  <= sat_p2;
        end
    end

    assign data_o_valid = (count != 2'd0);
    assign data_o       = head_data;
    assign sat_o        = head_sat;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: four configurations share one input stream; directed scenarios plus
// randomized traffic checked against an arithmetic/queue reference model.
module tb_cic_decimator;

    localparam int IW = 25;
    localparam int OW = 20;

    logic clk = 1'b0;
    logic rst, en, sync, clr, ready;
    logic signed [IW-1:0] din;
    logic vld [4];
    logic sat [4];
    logic ovf [4];
    logic signed [OW-1:0] dout [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: rounding (R=1,SHIFT=5)  1: R=4 PHASE=0  2: R=4 PHASE=3  3: R=1 SHIFT=0
    cic_decimator #(.width_H(5), .width_W(20), .R(1), .PHASE(0), .SHIFT(5), .OUT_W(OW)) u_rnd (
        .clk(clk), .rst(rst), .data_i_en(en), .data_i(din), .sync_i(sync), .overflow_clr(clr),
        .data_o_valid(vld[0]), .data_o_ready(ready), .data_o(dout[0]), .sat_o(sat[0]), .overflow(ovf[0]));
    cic_decimator #(.width_H(5), .width_W(20), .R(4), .PHASE(0), .SHIFT(0), .OUT_W(OW)) u_dec (
        .clk(clk), .rst(rst), .data_i_en(en), .data_i(din), .sync_i(sync), .overflow_clr(clr),
        .data_o_valid(vld[1]), .data_o_ready(ready), .data_o(dout[1]), .sat_o(sat[1]), .overflow(ovf[1]));
    cic_decimator #(.width_H(5), .width_W(20), .R(4), .PHASE(3), .SHIFT(0), .OUT_W(OW)) u_ph (
        .clk(clk), .rst(rst), .data_i_en(en), .data_i(din), .sync_i(sync), .overflow_clr(clr),
        .data_o_valid(vld[2]), .data_o_ready(ready), .data_o(dout[2]), .sat_o(sat[2]), .overflow(ovf[2]));
    cic_decimator #(.width_H(5), .width_W(20), .R(1), .PHASE(0), .SHIFT(0), .OUT_W(OW)) u_bp (
        .clk(clk), .rst(rst), .data_i_en(en), .data_i(din), .sync_i(sync), .overflow_clr(clr),
        .data_o_valid(vld[3]), .data_o_ready(ready), .data_o(dout[3]), .sat_o(sat[3]), .overflow(ovf[3]));

    // Reference model: kept samples become results due 3 edges later, then enter a 2-deep queue.
    int m_r  [4] = '{1, 4, 4, 1};
    int m_ph [4] = '{0, 0, 3, 0};
    int m_sh [4] = '{5, 0, 0, 0};

    typedef struct { int inst; int due; longint val; bit s; } pend_t;
    pend_t  pend [$];
    int     m_cnt [4];
    int     m_n [4];
    longint m_fv [4][2];
    bit     m_fs [4][2];
    longint m_last [4];
    bit     m_lsat [4];
    bit     m_ov [4];
    int     edge_n = 0;

    function automatic void ref_result(input longint x, input int s, output longint v, output bit st);
        longint d, sum, q, maxv, minv;
        d    = longint'(1) << s;
        sum  = x + d / 2;
        q    = sum / d;
        if ((sum % d != 0) && (sum < 0)) q = q - 1;
        maxv = (longint'(1) << (OW - 1)) - 1;
        minv = -(longint'(1) << (OW - 1));
        st   = 1'b0;
        v    = q;
        if (q > maxv) begin v = maxv; st = 1'b1; end
        if (q < minv) begin v = minv; st = 1'b1; end
    endfunction

    always @(negedge rst) begin
        pend.delete();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_n[i] = 0; m_last[i] = 0; m_lsat[i] = 1'b0; m_ov[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        bit popped, drop;
        int k;
        longint v;
        bit s;
        if (rst === 1'b1) begin
            edge_n++;
            for (int i = 0; i < 4; i++) begin
                popped = (m_n[i] > 0) && (ready === 1'b1);
                drop   = 1'b0;
                if (popped) begin
                    m_last[i]  = m_fv[i][0];
                    m_lsat[i]  = m_fs[i][0];
                    m_fv[i][0] = m_fv[i][1];
                    m_fs[i][0] = m_fs[i][1];
                    m_n[i]--;
                end
                for (int j = pend.size() - 1; j >= 0; j--) begin
                    if (pend[j].inst == i && pend[j].due == edge_n) begin
                        if (m_n[i] < 2) begin
                            m_fv[i][m_n[i]] = pend[j].val;
                            m_fs[i][m_n[i]] = pend[j].s;
                            m_n[i]++;
                        end else begin
                            drop = 1'b1;
                        end
                        pend.delete(j);
                    end
                end
                if (drop) m_ov[i] = 1'b1;
                else if (clr === 1'b1) m_ov[i] = 1'b0;
                if (en === 1'b1) begin
                    k = (sync === 1'b1) ? 0 : m_cnt[i];
                    if (k == m_ph[i]) begin
                        ref_result(longint'(din), m_sh[i], v, s);
                        pend.push_back('{i, edge_n + 3, v, s});
                    end
                    m_cnt[i] = (k + 1) % m_r[i];
                end else if (sync === 1'b1) begin
                    m_cnt[i] = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; din = '0; sync = 1'b0; clr = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; din = '0; sync = 1'b0; clr = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (vld[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", i, vld[i]); end
            checks++; if (dout[i] !== '0) begin errors++; $display("FAIL reset_data[%0d]: got %0d want 0", i, dout[i]); end
            checks++; if (sat[i] !== 1'b0) begin errors++; $display("FAIL reset_sat[%0d]: got %b want 0", i, sat[i]); end
            checks++; if (ovf[i] !== 1'b0) begin errors++; $display("FAIL reset_overflow[%0d]: got %b want 0", i, ovf[i]); end
        end
        rst = 1'b1;
    endtask

    task automatic test_rounding();
        int vals [5] = '{32000, 47, 48, -48, -49};
        int expv [5] = '{1000, 1, 2, -1, -2};
        do_reset();
        for (int n = 0; n < 10; n++) begin
            if (n >= 4 && n <= 8) begin
                checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %b want 1", n - 4, vld[0]); end
                checks++; if (dout[0] !== OW'(expv[n-4])) begin errors++; $display("FAIL round_data[%0d]: got %0d want %0d", n - 4, dout[0], expv[n-4]); end
                checks++; if (sat[0] !== 1'b0) begin errors++; $display("FAIL round_sat[%0d]: got %b want 0", n - 4, sat[0]); end
            end else begin
                checks++; if (vld[0] !== 1'b0) begin errors++; $display("FAIL round_idle_valid[%0d]: got %b want 0", n, vld[0]); end
            end
            en  = (n < 5);
            din = (n < 5) ? IW'(vals[n]) : '0;
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        int vals [2] = '{16777215, -16777216};
        int expv [2] = '{524287, -524288};
        bit exps [2] = '{1'b1, 1'b0};
        do_reset();
        for (int n = 0; n < 7; n++) begin
            if (n >= 4 && n <= 5) begin
                checks++; if (vld[0] !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b want 1", n - 4, vld[0]); end
                checks++; if (dout[0] !== OW'(expv[n-4])) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", n - 4, dout[0], expv[n-4]); end
                checks++; if (sat[0] !== exps[n-4]) begin errors++; $display("FAIL sat_flag[%0d]: got %b want %b", n - 4, sat[0], exps[n-4]); end
            end
            en  = (n < 2);
            din = (n < 2) ? IW'(vals[n]) : '0;
            @(negedge clk);
        end
    endtask

    task automatic test_decimation();
        logic signed [OW-1:0] got [$];
        int exp_a [4] = '{0, 4, 8, 12};
        int exp_s [5] = '{0, 4, 6, 10, 14};
        int v;
        for (int mode = 0; mode < 3; mode++) begin
            do_reset();
            got.delete();
            v = 0;
            for (int n = 0; n < 44; n++) begin
                if (vld[1] === 1'b1) got.push_back(dout[1]);
                en   = (mode == 1) ? ((n % 2 == 0) && (v < 16)) : (n < 16);
                din  = IW'((mode == 1) ? v : n);
                sync = (mode == 2) && (n == 6);
                if (en) v++;
                @(negedge clk);
            end
            en = 1'b0; sync = 1'b0;
            if (mode < 2) begin
                checks++; if (got.size() != 4) begin errors++; $display("FAIL dec_count[mode %0d]: got %0d want 4", mode, got.size()); end
                for (int k = 0; k < 4 && k < got.size(); k++) begin
                    checks++; if (got[k] !== OW'(exp_a[k])) begin errors++; $display("FAIL dec_data[mode %0d,%0d]: got %0d want %0d", mode, k, got[k], exp_a[k]); end
                end
            end else begin
                checks++; if (got.size() != 5) begin errors++; $display("FAIL sync_count: got %0d want 5", got.size()); end
                for (int k = 0; k < 5 && k < got.size(); k++) begin
                    checks++; if (got[k] !== OW'(exp_s[k])) begin errors++; $display("FAIL sync_data[%0d]: got %0d want %0d", k, got[k], exp_s[k]); end
                end
            end
        end
    endtask

    task automatic test_phase();
        logic signed [OW-1:0] got [$];
        int expv [3] = '{3, 7, 11};
        do_reset();
        for (int n = 0; n < 22; n++) begin
            if (vld[2] === 1'b1) got.push_back(dout[2]);
            en  = (n < 12);
            din = IW'(n);
            @(negedge clk);
        end
        en = 1'b0;
        checks++; if (got.size() != 3) begin errors++; $display("FAIL phase_count: got %0d want 3", got.size()); end
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            checks++; if (got[k] !== OW'(expv[k])) begin errors++; $display("FAIL phase_data[%0d]: got %0d want %0d", k, got[k], expv[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            en = (n < 3); din = IW'(n + 1);
            @(negedge clk);
        end
        en = 1'b0;
        checks++; if (ovf[3] !== 1'b1) begin errors++; $display("FAIL bp_overflow_set: got %b want 1", ovf[3]); end
        for (int n = 0; n < 3; n++) begin
            checks++; if (vld[3] !== 1'b1 || dout[3] !== OW'(1)) begin errors++; $display("FAIL bp_hold[%0d]: got valid %b data %0d want valid 1 data 1", n, vld[3], dout[3]); end
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        checks++; if (vld[3] !== 1'b1 || dout[3] !== OW'(2)) begin errors++; $display("FAIL bp_second: got valid %b data %0d want valid 1 data 2", vld[3], dout[3]); end
        @(negedge clk);
        checks++; if (vld[3] !== 1'b0 || dout[3] !== OW'(2)) begin errors++; $display("FAIL bp_empty: got valid %b data %0d want valid 0 data 2", vld[3], dout[3]); end
        ready = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (ovf[3] !== 1'b0) begin errors++; $display("FAIL bp_overflow_clear: got %b want 0", ovf[3]); end
        // full buffer, pop and push on the same edge
        en = 1'b1; din = IW'(10); @(negedge clk);
        din = IW'(11); @(negedge clk);
        din = IW'(12); @(negedge clk);
        en = 1'b0; @(negedge clk);
        @(negedge clk);
        checks++; if (vld[3] !== 1'b1 || dout[3] !== OW'(10)) begin errors++; $display("FAIL pp_full_head: got valid %b data %0d want valid 1 data 10", vld[3], dout[3]); end
        ready = 1'b1; @(negedge clk);
        ready = 1'b0;
        checks++; if (dout[3] !== OW'(11) || ovf[3] !== 1'b0) begin errors++; $display("FAIL pp_no_drop: got data %0d overflow %b want data 11 overflow 0", dout[3], ovf[3]); end
        ready = 1'b1; @(negedge clk);
        checks++; if (vld[3] !== 1'b1 || dout[3] !== OW'(12)) begin errors++; $display("FAIL pp_tail: got valid %b data %0d want valid 1 data 12", vld[3], dout[3]); end
        @(negedge clk);
        checks++; if (vld[3] !== 1'b0) begin errors++; $display("FAIL pp_drained: got valid %b want 0", vld[3]); end
        // clear coinciding with a fresh drop
        ready = 1'b0;
        en = 1'b1; din = IW'(20); @(negedge clk);
        din = IW'(21); @(negedge clk);
        din = IW'(22); @(negedge clk);
        en = 1'b0; @(negedge clk);
        @(negedge clk);
        checks++; if (ovf[3] !== 1'b0) begin errors++; $display("FAIL clr_pre: got %b want 0", ovf[3]); end
        clr = 1'b1; @(negedge clk);
        clr = 1'b0;
        checks++; if (ovf[3] !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", ovf[3]); end
        ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic signed [OW-1:0] got1 [$];
        logic signed [OW-1:0] got3 [$];
        int s [5] = '{1048576, 2, 3, 7, 8};
        do_reset();
        ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            en = 1'b1; din = IW'(s[n]);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        checks++; if (vld[3] !== 1'b1 || dout[3] !== OW'(524287) || sat[3] !== 1'b1 || ovf[3] !== 1'b1)
            begin errors++; $display("FAIL ar_pre: got valid %b data %0d sat %b ovf %b want 1 524287 1 1", vld[3], dout[3], sat[3], ovf[3]); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (vld[3] !== 1'b0 || dout[3] !== '0 || sat[3] !== 1'b0 || ovf[3] !== 1'b0)
            begin errors++; $display("FAIL ar_immediate: got valid %b data %0d sat %b ovf %b want all 0", vld[3], dout[3], sat[3], ovf[3]); end
        @(negedge clk);
        rst = 1'b1; ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            checks++; if (vld[3] !== 1'b0) begin errors++; $display("FAIL ar_flushed[%0d]: got valid %b want 0", n, vld[3]); end
            @(negedge clk);
        end
        for (int n = 0; n < 16; n++) begin
            if (vld[1] === 1'b1) got1.push_back(dout[1]);
            if (vld[3] === 1'b1) got3.push_back(dout[3]);
            en = (n < 8); din = IW'(100 + n);
            @(negedge clk);
        end
        en = 1'b0;
        checks++; if (got1.size() != 2 || got1[0] !== OW'(100) || got1[1] !== OW'(104))
            begin errors++; $display("FAIL ar_first_kept: got count %0d first %0d want 2 results 100 104", got1.size(), (got1.size() > 0) ? got1[0] : '0); end
        checks++; if (got3.size() != 8 || got3[0] !== OW'(100))
            begin errors++; $display("FAIL ar_stream: got count %0d first %0d want 8 results from 100", got3.size(), (got3.size() > 0) ? got3[0] : '0); end
    endtask

    task automatic test_random();
        logic signed [OW-1:0] ed;
        bit es;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                ed = (m_n[i] > 0) ? OW'(m_fv[i][0]) : OW'(m_last[i]);
                es = (m_n[i] > 0) ? m_fs[i][0] : m_lsat[i];
                checks++; if (vld[i] !== (m_n[i] > 0)) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", i, n, vld[i], m_n[i] > 0); end
                checks++; if (dout[i] !== ed) begin errors++; $display("FAIL rnd_data[%0d] cyc %0d: got %0d want %0d", i, n, dout[i], ed); end
                checks++; if (sat[i] !== es) begin errors++; $display("FAIL rnd_sat[%0d] cyc %0d: got %b want %b", i, n, sat[i], es); end
                checks++; if (ovf[i] !== m_ov[i]) begin errors++; $display("FAIL rnd_overflow[%0d] cyc %0d: got %b want %b", i, n, ovf[i], m_ov[i]); end
            end
            en    = ($urandom_range(0, 3) != 0);
            din   = IW'($urandom);
            din   = din >>> $urandom_range(0, 12);
            sync  = ($urandom_range(0, 15) == 0);
            clr   = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        en = 1'b0; sync = 1'b0; clr = 1'b0; ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_phase();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Downstream stage of the single-stage CIC moving-sum block. Consumes its data_o_en/data_o stream and decimates by R.
- Removes the CIC gain with a rounded arithmetic right shift, then saturates to OUT_W bits.
- Delivers results over a valid/ready interface through a 2-entry output buffer, with a sticky overflow flag for dropped results.

Parameters:
- width_H, 5, guard (growth) bits of the input word.
- width_W, 20, base bits of the input word. Input width IW = width_H+width_W.
- R, 32, decimation ratio, R >= 1.
- PHASE, 0, counter value at which a sample is kept, 0 <= PHASE < R.
- SHIFT, 5, gain-removal right shift, 0 <= SHIFT < IW.
- OUT_W, 20, output width, OUT_W <= IW+1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- data_i_en  in  1  input sample strobe.
- data_i  in  IW  signed two's-complement CIC output sample.
- sync_i  in  1  decimation counter realign.
- overflow_clr  in  1  clears the sticky overflow flag.
- data_o_valid  out  1  output buffer head is valid.
- data_o_ready  in  1  consumer accepts the head this cycle.
- data_o  out  OUT_W  signed decimated result.
- sat_o  out  1  saturation flag, travels with data_o.
- overflow  out  1  sticky flag: a result was dropped because the buffer was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_o_valid=0, data_o=0, sat_o=0, overflow=0.
  - Decimation counter cnt=0; buffer empty; all pipeline valids cleared.
  - Asserting reset mid-operation discards every in-flight sample and buffered result.
- Decimation counter:
  - On each data_i_en=1, cnt advances 0..R-1 and wraps to 0.
  - The sample is kept when the pre-increment cnt equals PHASE.
  - sync_i=1 forces cnt to 0. If data_i_en=1 in the same cycle, that sample is treated as cnt=0: kept if PHASE==0, and cnt becomes 1 (or 0 when R==1).
  - Cycles with data_i_en=0 do not advance cnt.
- Pipeline: 3 stages, each with a valid tag. Stages advance every clock and never stall.
  - S1 registers the kept sample.
  - S2 adds 2^(SHIFT-1) in IW+1 bits, then shifts right arithmetically by SHIFT. This is round-half-up (toward +inf). When SHIFT=0 there is no add and no shift.
  - S3 saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat=1 when clamped, and is stored with the result.
- Latency:
  - A kept sample strobed at edge t produces an S3 result at edge t+3.
  - If the buffer was empty, data_o_valid=1 and data_o are visible after edge t+3.
- Output buffer: 2-entry FIFO; the head drives data_o/sat_o.
  - Pop when data_o_valid & data_o_ready.
  - data_o and sat_o hold stable while valid=1 and ready=0.
  - When empty, data_o holds its last value and valid=0.
- Buffer full:
  - An S3 result arriving while the buffer is full with no pop that cycle is dropped, and overflow is set.
  - Full with a pop in the same cycle: the pop frees a slot and the new result is accepted. No drop.
- Overflow flag: overflow_clr=1 clears it. If a new drop and overflow_clr occur in the same cycle, set wins.
- Input contract: data_i_en is a continuous stream. data_o_ready never back-pressures the input.

Test Plan:
- Rounding (R=1, SHIFT=5, OUT_W=20): inputs 32000, 47, 48, -48, -49 -> data_o 1000, 1, 2, -1, -2 with sat_o=0. Each appears 3 cycles after its strobe; ready=1 throughout.
- Saturation (same config): input 16777215 -> data_o 524287, sat_o=1. Input -16777216 -> data_o -524288, sat_o=0.
- Decimation (R=4, PHASE=0, SHIFT=0): ramp 0,1,2,... with data_i_en=1 every cycle -> outputs 0, 4, 8, 12.
  - Repeat with data_i_en toggling every other cycle -> same output values.
  - Pulse sync_i alongside sample 6 -> subsequent outputs 6, 10, 14.
- PHASE (R=4, PHASE=3, SHIFT=0): ramp from 0 -> outputs 3, 7, 11.
- Backpressure (R=1, SHIFT=0): hold ready=0, feed 1, 2, 3.
  - Required: data_o stays 1 with valid=1; 3 is dropped; overflow=1.
  - Then ready=1 -> outputs 1, 2 and valid drops.
  - Full with pop and push in the same cycle -> no drop.
  - overflow_clr together with a new drop -> overflow stays 1.
- Async reset mid-stream: assert rst=0 between edges while the buffer holds 2 entries -> valid, data_o, overflow and sat_o go to 0 immediately.
  - After release, the first kept sample is the first strobed one (cnt=0, PHASE=0).
